fetch_stage: RTL

//  Instruction-fetch front end directly upstream of instruction_cache. Owns the 64-bit PC,

---
 rtl/riscv_pkg.sv | 30 +++
 rtl/fetch_buffer.sv | 63 ++++++
 rtl/fetch_stage.sv | 129 ++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-path types: PC/instruction widths, fetch FSM states,
// and the {pc, instr, misalign} bundle carried from fetch to decode.
package riscv_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEF = '0;

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        MISS,
        FULL
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
        logic            misalign;
    } fetch_entry_t;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [XLEN-1:0] align_pc(
        input logic [XLEN-1:0] pc
    );
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small FIFO of fetch entries between the PC/cache side and decode.
// Same-cycle push and pop are allowed; a pop frees room for a push.
module fetch_buffer
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t data_i,
    output fetch_entry_t data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign data_o  = mem_q[rd_ptr_q];

    // Pointer and occupancy tracking; flush drops everything at once.
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Entry storage; no reset needed since empty gates the outputs.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i && !reset) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Fetch front end: owns the PC, talks to the instruction cache and
// hands {pc, instr, misalign} to decode over a valid/ready handshake.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
    parameter int unsigned     BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] icache_pc,
    input  logic            icache_r,
    input  logic [ILEN-1:0] icache_instr,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            fe_valid,
    input  logic            fe_ready,
    output logic [XLEN-1:0] fe_pc,
    output logic [ILEN-1:0] fe_instr,
    output logic            fe_misalign,
    output logic [31:0]     miss_cycles
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            mis_q, mis_d;
    logic [31:0]     miss_q, miss_d;

    logic            push;
    logic            pop;
    logic            can_push;
    logic            buf_full;
    logic            buf_empty;
    fetch_entry_t    wr_entry;
    fetch_entry_t    head;

    assign icache_pc = pc_q;
    assign pop       = fe_valid & fe_ready;
    assign can_push  = ~buf_full | pop;

    assign wr_entry.pc       = pc_q;
    assign wr_entry.instr    = icache_instr;
    assign wr_entry.misalign = mis_q;

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .data_i  (wr_entry),
        .data_o  (head),
        .full_o  (buf_full),
        .empty_o (buf_empty)
    );

    // Outputs read as zero whenever nothing is being presented.
    assign fe_valid    = ~buf_empty;
    assign fe_pc       = buf_empty ? '0 : head.pc;
    assign fe_instr    = buf_empty ? '0 : head.instr;
    assign fe_misalign = buf_empty ? 1'b0 : head.misalign;
    assign miss_cycles = miss_q;

    // Next-state: capture on hit when room exists, redirect wins.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        mis_d   = mis_q;
        miss_d  = miss_q;
        push    = 1'b0;

        if (state_q == MISS && miss_q != '1) begin
            miss_d = miss_q + 1'b1;
        end

        unique case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH, MISS: begin
                if (icache_r) begin
                    if (can_push) begin
                        push    = 1'b1;
                        pc_d    = pc_q + XLEN'(4);
                        mis_d   = 1'b0;
                        state_d = FETCH;
                    end else begin
                        state_d = FULL;
                    end
                end else begin
                    state_d = MISS;
                end
            end
            FULL: begin
                if (pop) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        if (redirect_valid) begin
            push    = 1'b0;
            pc_d    = align_pc(redirect_pc);
            mis_d   = |redirect_pc[1:0];
            state_d = FETCH;
        end
    end

    // PC, FSM, misalign flag and miss counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            mis_q   <= 1'b0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            mis_q   <= mis_d;
            miss_q  <= miss_d;
        end
    end

endmodule
